// File: rtl/hello_scroller_pkg.sv
// Character codes and the fixed "HELLO" message for the scroller.
// Codes 4..7 render as blank on the downstream HELO decoder.
package hello_pkg;

   typedef logic [2:0] char_code_t;

   localparam char_code_t CH_H     = 3'd0;
   localparam char_code_t CH_E     = 3'd1;
   localparam char_code_t CH_L     = 3'd2;
   localparam char_code_t CH_O     = 3'd3;
   localparam char_code_t CH_BLANK = 3'd4;

   function automatic char_code_t msg_char(input int unsigned idx);
      case (idx)
         0:       return CH_H;
         1:       return CH_E;
         2, 3:    return CH_L;
         4:       return CH_O;
         default: return CH_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/hello_scroller_prescaler.sv
// Enable-gated divider: tick_evt is combinational in the last count of each period.
// Dropping en clears the count, so re-enabling always yields a full period.
module tick_prescaler #(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick_evt
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!en || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick_evt = en && (cnt == LAST);

endmodule

// File: rtl/hello_scroller.sv
// Scrolls "HELLO" plus blanks across NUM_DISP displays, timed or by button step.
// New pos/hex_codes appear one cycle after an advance event, flagged by tick.
module hello_scroller
   import hello_pkg::*;
#(
   parameter int unsigned NUM_DISP = 8,
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        run,
   input  logic                        dir,
   input  logic                        step,
   output logic [3*NUM_DISP-1:0]       hex_codes,
   output logic [$clog2(NUM_DISP)-1:0] pos,
   output logic                        tick
);

   localparam int unsigned PW = $clog2(NUM_DISP);
   localparam logic [PW-1:0] LASTP = PW'(NUM_DISP - 1);

   logic          timed_evt;
   logic          step_q;
   logic          step_edge;
   logic          adv;
   logic [PW-1:0] next_pos;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (run),
      .tick_evt (timed_evt)
   );

   // Button steps only count while paused; timed_evt already implies run=1.
   assign step_edge = step & ~step_q;
   assign adv       = timed_evt | (~run & step_edge);

   always_comb begin
      next_pos = pos;
      if (!dir) begin
         next_pos = (pos == LASTP) ? '0 : pos + PW'(1);
      end else begin
         next_pos = (pos == '0) ? LASTP : pos - PW'(1);
      end
   end

   // step_q resets high so a button held through reset is not seen as an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos    <= '0;
         tick   <= 1'b0;
         step_q <= 1'b1;
      end else begin
         step_q <= step;
         tick   <= adv;
         if (adv) begin
            pos <= next_pos;
         end
      end
   end

   for (genvar k = 0; k < int'(NUM_DISP); k++) begin : g_disp
      localparam int unsigned BASE = NUM_DISP - 1 - k;
      assign hex_codes[3*k +: 3] = msg_char((BASE + 32'(pos)) % NUM_DISP);
   end

endmodule

// File: tb/tb_hello_scroller.sv
// Directed bench for hello_scroller: NUM_DISP=8 with TICK_DIV=4, plus a TICK_DIV=1 instance.
module tb_hello_scroller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic        run1 = 1'b0;
   logic        dir = 1'b0;
   logic        step = 1'b1;
   logic [23:0] hex_codes;
   logic [2:0]  pos;
   logic        tick;
   logic [23:0] hex_codes1;
   logic [2:0]  pos1;
   logic        tick1;

   int tests = 0;
   int fails = 0;

   localparam logic [23:0] HEX_P0 = 24'h052724;
   localparam logic [23:0] HEX_P1 = 24'h293920;
   localparam logic [23:0] HEX_P7 = 24'h80A4E4;

   always #5 clk = ~clk;

   hello_scroller #(.NUM_DISP(8), .TICK_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .dir(dir), .step(step),
      .hex_codes(hex_codes), .pos(pos), .tick(tick)
   );

   hello_scroller #(.NUM_DISP(8), .TICK_DIV(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .run(run1), .dir(dir), .step(step),
      .hex_codes(hex_codes1), .pos(pos1), .tick(tick1)
   );

   // Stimulus only: pulse reset and release it at a falling edge.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      run = 1'b0; dir = 1'b0; step = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      tests++; if (hex_codes !== HEX_P0) begin fails++; $display("FAIL reset_hex got %h exp %h", hex_codes, HEX_P0); end
      tests++; if (pos !== 3'd0) begin fails++; $display("FAIL reset_pos got %0d exp 0", pos); end
      tests++; if (tick !== 1'b0) begin fails++; $display("FAIL reset_tick got %b exp 0", tick); end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         tests++; if (tick !== 1'b0 || pos !== 3'd0) begin fails++; $display("FAIL reset_held_step got tick=%b pos=%0d exp tick=0 pos=0", tick, pos); end
      end
   endtask

   task automatic test_step_left();
      int ticks = 0;
      step = 1'b0;
      repeat (2) @(negedge clk);
      step = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (tick === 1'b1) ticks++;
      end
      tests++; if (ticks != 1) begin fails++; $display("FAIL step_left_ticks got %0d exp 1", ticks); end
      tests++; if (pos !== 3'd1) begin fails++; $display("FAIL step_left_pos got %0d exp 1", pos); end
      tests++; if (hex_codes !== HEX_P1) begin fails++; $display("FAIL step_left_hex got %h exp %h", hex_codes, HEX_P1); end
   endtask

   task automatic test_step_right();
      dir = 1'b1; step = 1'b0; run = 1'b0;
      do_reset();
      @(negedge clk);
      step = 1'b1;
      repeat (2) @(negedge clk);
      tests++; if (pos !== 3'd7) begin fails++; $display("FAIL step_right_pos got %0d exp 7", pos); end
      tests++; if (hex_codes !== HEX_P7) begin fails++; $display("FAIL step_right_hex got %h exp %h", hex_codes, HEX_P7); end
      step = 1'b0;
      @(negedge clk);
      step = 1'b1;
      repeat (2) @(negedge clk);
      tests++; if (pos !== 3'd6) begin fails++; $display("FAIL step_right_pos2 got %0d exp 6", pos); end
      dir = 1'b0; step = 1'b0;
   endtask

   // Leaves the DUT in cycle 32 (count 0, pos 0) for test_pause_resume.
   task automatic test_run_scroll();
      run = 1'b1; dir = 1'b0; step = 1'b0;
      do_reset();
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         tests++;
         if (tick !== (k % 4 == 0)) begin
            fails++; $display("FAIL run_tick_c%0d got %b exp %b", k, tick, (k % 4 == 0));
         end
         if (k == 4) begin
            tests++; if (pos !== 3'd1) begin fails++; $display("FAIL run_pos_c4 got %0d exp 1", pos); end
         end
      end
      tests++; if (pos !== 3'd0) begin fails++; $display("FAIL run_pos_wrap got %0d exp 0", pos); end
      tests++; if (hex_codes !== HEX_P0) begin fails++; $display("FAIL run_hex_wrap got %h exp %h", hex_codes, HEX_P0); end
   endtask

   task automatic test_pause_resume();
      int ticks;
      repeat (2) @(negedge clk);
      run = 1'b0;
      repeat (5) begin
         @(negedge clk);
         tests++; if (tick !== 1'b0) begin fails++; $display("FAIL pause_tick got %b exp 0", tick); end
      end
      tests++; if (pos !== 3'd0) begin fails++; $display("FAIL pause_pos got %0d exp 0", pos); end
      run = 1'b1; step = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         tests++;
         if (tick !== (i == 4)) begin fails++; $display("FAIL resume_tick_i%0d got %b exp %b", i, tick, (i == 4)); end
      end
      tests++; if (pos !== 3'd1) begin fails++; $display("FAIL resume_pos got %0d exp 1", pos); end
      step = 1'b0;
      repeat (3) @(negedge clk);
      // Count is at its last value here: dropping run must cancel the timed advance,
      // while the coincident step edge gives exactly one advance.
      run = 1'b0; step = 1'b1;
      ticks = 0;
      repeat (4) begin
         @(negedge clk);
         if (tick === 1'b1) ticks++;
      end
      tests++; if (ticks != 1) begin fails++; $display("FAIL drop_run_step_ticks got %0d exp 1", ticks); end
      tests++; if (pos !== 3'd2) begin fails++; $display("FAIL drop_run_step_pos got %0d exp 2", pos); end
   endtask

   task automatic test_async_reset();
      step = 1'b0;
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      tests++; if (pos !== 3'd3) begin fails++; $display("FAIL pre_async_pos got %0d exp 3", pos); end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests++; if (pos !== 3'd0) begin fails++; $display("FAIL async_pos got %0d exp 0", pos); end
      tests++; if (tick !== 1'b0) begin fails++; $display("FAIL async_tick got %b exp 0", tick); end
      tests++; if (hex_codes !== HEX_P0) begin fails++; $display("FAIL async_hex got %h exp %h", hex_codes, HEX_P0); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_tick_div1();
      run1 = 1'b1; step = 1'b0; dir = 1'b0;
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         tests++;
         if (pos1 !== 3'(k % 8) || tick1 !== 1'b1) begin
            fails++; $display("FAIL div1_c%0d got pos=%0d tick=%b exp pos=%0d tick=1", k, pos1, tick1, k % 8);
         end
      end
      run1 = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_step_left();
      test_step_right();
      test_run_scroll();
      test_pause_resume();
      test_async_reset();
      test_tick_div1();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hello_scroller.md
Name: hello_scroller

Overview:
- Upstream source of 3-bit character codes for a row of per-digit HELO seven-segment decoders.
- Holds an N-position rotation counter and scrolls the message "HELLO" plus trailing blanks across NUM_DISP displays.
- Scrolls on a prescaled tick while running, or by single button steps while paused.
- Output codes: 0=H, 1=E, 2=L, 3=O, 4=blank. The downstream decoder shows codes 4..7 as blank.

Parameters:
- NUM_DISP, 8, number of displays driven; must be >= 5.
- TICK_DIV, 50_000_000, clock cycles per automatic advance (1 s at 50 MHz); must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- run  in  1  level; 1 = automatic scrolling, 0 = paused.
- dir  in  1  0 = scroll left, 1 = scroll right.
- step  in  1  level from a debounced button; each rising edge advances one position while paused.
- hex_codes  out  3*NUM_DISP  display k code at bits [3k+2:3k]; display 0 is rightmost.
- pos  out  $clog2(NUM_DISP)  current rotation offset.
- tick  out  1  one-cycle pulse marking the cycle in which a new pos/hex_codes first appears.

Interface note: one clock, clk; reset rst_n is asynchronous, active-low.

Behaviour:
- Message: msg[0..NUM_DISP-1] = H,E,L,L,O, then blank for indices 5..NUM_DISP-1.
- Display mapping: display k shows msg[(NUM_DISP-1-k+pos) mod NUM_DISP]. hex_codes is a pure function of the pos register, with no added latency.
- Reset (async, immediate, also mid-operation):
  - pos=0, prescaler=0, tick=0, step_q=1.
  - hex_codes shows HELLO left-justified; for NUM_DISP=8 this is 24'h052724.
  - step_q resets to 1 so a button held through reset does not cause a step.
- Prescaler:
  - While run=1, counts 0..TICK_DIV-1 and wraps to 0; a timed advance event occurs in the cycle where count==TICK_DIV-1.
  - While run=0, the counter is forced to 0, so resuming always gives a full period.
  - TICK_DIV=1 gives an advance every cycle while run=1.
- Step:
  - step_q registers step every cycle; step_edge = step & ~step_q.
  - step_edge causes an advance event only when run=0. When run=1 it is ignored and not queued.
- Advance event in cycle t:
  - At the end of t, pos becomes pos+1 if dir=0 or pos-1 if dir=1, modulo NUM_DISP.
  - Wrap: NUM_DISP-1 -> 0 (left); 0 -> NUM_DISP-1 (right).
  - tick=1 in cycle t+1 only. New pos and hex_codes are visible in t+1.
- dir is sampled only at an advance event; changing it between events has no other effect.
- run falling edge in the same cycle as count==TICK_DIV-1: no advance (run is sampled first).
- Simultaneous run=0 and step_edge: exactly one advance.
- Counter widths: max(1, $clog2(TICK_DIV)) and max(1, $clog2(NUM_DISP)). All arithmetic is unsigned with explicit modulo; no reliance on power-of-2 wrap.

Decomposition:
- Package hello_pkg:
  - typedef logic [2:0] char_code_t.
  - Constants CH_H=0, CH_E=1, CH_L=2, CH_O=3, CH_BLANK=4.
  - Function msg_char(idx) returning the message character.
- Sub-module tick_prescaler (params TICK_DIV; ports clk, rst_n, en, tick_evt): the enable-clearing divider.
- Top level holds the step edge detect, pos register, tick register and generate loop for display mapping.

Test Plan (NUM_DISP=8, TICK_DIV=4 unless stated):
- Reset held, run=0, step=1 through reset release -> hex_codes=24'h052724, pos=0, tick=0; no advance on the first cycle after release.
- run=0, dir=0, one step pulse (0->1 held 3 cycles) -> exactly one tick; pos=1; hex_codes=24'h293920.
- From reset, run=0, dir=1, one step pulse -> pos=7, hex_codes=24'h80A4E4; second step -> pos=6.
- run=1, dir=0 from the cycle after reset -> tick in cycles 4, 8, 12...; after 8 advances (cycle 32) pos=0 and hex_codes=24'h052724 again.
- run=1, drop run at count=2, raise again 5 cycles later -> no advance while low; next tick exactly 4 cycles after run returns; step pulses while run=1 produce no extra advance.
- Mid-scroll (pos=3), assert rst_n=0 asynchronously between edges -> pos=0, tick=0 and hex_codes=24'h052724 before the next clk edge; TICK_DIV=1 run: pos increments every cycle.
